// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing defaults and counter types for the scan-out path.
// Contents: DEF_* timing defaults, HT/VT totals, SRC_W/SRC_H source image size,
// and the hcnt_t/vcnt_t counter typedefs.
package video_timing_pkg;

    localparam int unsigned DEF_CLKS_PER_PIXEL = 2;
    localparam int unsigned DEF_H_VISIBLE      = 640;
    localparam int unsigned DEF_H_FRONT        = 16;
    localparam int unsigned DEF_H_SYNC         = 96;
    localparam int unsigned DEF_H_BACK         = 48;
    localparam int unsigned DEF_V_VISIBLE      = 480;
    localparam int unsigned DEF_V_FRONT        = 10;
    localparam int unsigned DEF_V_SYNC         = 2;
    localparam int unsigned DEF_V_BACK         = 33;
    localparam int unsigned DEF_VEND_LEAD      = 3;

    localparam int unsigned HT = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned VT = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned SRC_W = 320;
    localparam int unsigned SRC_H = 240;

    typedef logic [9:0] hcnt_t;
    typedef logic [9:0] vcnt_t;

endpackage

// File: rtl/video_timing_gen.sv
// Pixel/line timing generator with PPU pacing strobes.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   pix_stb           1-clk pixel-rate enable (last phase of each pixel)
//   src_x             source column h[9:1] (row-buffer address)
//   raw_de/hsync/vsync undelayed DE and active-low syncs for the current (h, v)
//   rowram_swap       1-clk pulse at selected line ends; next_row valid with it
//   next_row          source row the PPU renders next; holds between swaps
//   vblank_start      1-clk pulse at end of the last visible line
//   vblank_end_soon   1-clk pulse VEND_LEAD lines before line 0
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
    parameter int unsigned H_VISIBLE      = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT        = DEF_H_FRONT,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BACK         = DEF_H_BACK,
    parameter int unsigned V_VISIBLE      = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT        = DEF_V_FRONT,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BACK         = DEF_V_BACK,
    parameter int unsigned VEND_LEAD      = DEF_VEND_LEAD
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_stb,
    output logic [8:0] src_x,
    output logic       raw_de,
    output logic       raw_hsync,
    output logic       raw_vsync,
    output logic       rowram_swap,
    output logic [7:0] next_row,
    output logic       vblank_start,
    output logic       vblank_end_soon
);

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned PHASE_W   = $clog2(CLKS_PER_PIXEL);
    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC;
    localparam int unsigned VEND_LINE = V_TOTAL - 1 - VEND_LEAD;
    // Row 0 is rendered twice: primed late in vblank, then re-requested at the
    // end of the frame into a buffer that is never shown.
    localparam int unsigned PRIME_LINE = V_TOTAL - 3;
    localparam int unsigned LAST_LINE  = V_VISIBLE - 3;

    logic [PHASE_W-1:0] phase;
    hcnt_t              h;
    vcnt_t              v;
    logic               line_end;
    logic               swap_hit;
    logic [7:0]         swap_row;
    logic [7:0]         held_row;

    assign pix_stb  = (phase == PHASE_W'(CLKS_PER_PIXEL - 1));
    assign line_end = pix_stb && (h == hcnt_t'(H_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            h     <= '0;
            v     <= vcnt_t'(V_VISIBLE);
        end else begin
            phase <= pix_stb ? '0 : phase + 1'b1;
            if (line_end) begin
                h <= '0;
                v <= (v == vcnt_t'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else if (pix_stb) begin
                h <= h + 1'b1;
            end
        end
    end

    // Each odd line finishes scanning source row s = v>>1, so the PPU moves on
    // to row s+2 (row s+1 is already in the back buffer).
    always_comb begin
        swap_hit = 1'b0;
        swap_row = '0;
        if (v == vcnt_t'(PRIME_LINE)) begin
            swap_hit = 1'b1;
        end else if (v == vcnt_t'(V_TOTAL - 1)) begin
            swap_hit = 1'b1;
            swap_row = 8'd1;
        end else if (v == vcnt_t'(LAST_LINE)) begin
            swap_hit = 1'b1;
        end else if (v[0] && (v < vcnt_t'(LAST_LINE))) begin
            swap_hit = 1'b1;
            swap_row = 8'(v[9:1]) + 8'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_row <= '0;
        end else if (rowram_swap) begin
            held_row <= swap_row;
        end
    end

    assign rowram_swap     = line_end && swap_hit;
    assign next_row        = rowram_swap ? swap_row : held_row;
    assign vblank_start    = line_end && (v == vcnt_t'(V_VISIBLE - 1));
    assign vblank_end_soon = line_end && (v == vcnt_t'(VEND_LINE));

    assign src_x     = h[9:1];
    assign raw_de    = (h < hcnt_t'(H_VISIBLE)) && (v < vcnt_t'(V_VISIBLE));
    assign raw_hsync = !((h >= hcnt_t'(HS_START)) && (h < hcnt_t'(HS_END)));
    assign raw_vsync = !((v >= vcnt_t'(VS_START)) && (v < vcnt_t'(VS_END)));

endmodule

// File: rtl/hdmi_video_output.sv
// Scan-out stage: 640x480@60 timing, 2x upscaled row-buffer/palette fetch,
// 24-bit RGB + DE/HS/VS to the HDMI transmitter, and PPU pacing strobes.
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   hdmi_rowram_rdaddr/rddata  row-buffer read (1 clk latency), 10-bit index
//   hdmi_palram_rdaddr/rddata  palette read (1 clk latency), 2 colours/word
//   rowram_swap, next_row      PPU row-buffer swap pulse and next source row
//   vblank_start, vblank_end_soon  PPU frame pacing pulses
//   pix_stb                    pixel-rate enable
//   hdmi_de/hsync/vsync/rgb    video stream, 2 pixels behind the counters
module hdmi_video_output
    import video_timing_pkg::*;
#(
    parameter int unsigned CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
    parameter int unsigned H_VISIBLE      = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT        = DEF_H_FRONT,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BACK         = DEF_H_BACK,
    parameter int unsigned V_VISIBLE      = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT        = DEF_V_FRONT,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BACK         = DEF_V_BACK,
    parameter int unsigned VEND_LEAD      = DEF_VEND_LEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [8:0]  hdmi_rowram_rdaddr,
    input  logic [9:0]  hdmi_rowram_rddata,
    output logic [8:0]  hdmi_palram_rdaddr,
    input  logic [63:0] hdmi_palram_rddata,
    output logic        rowram_swap,
    output logic [7:0]  next_row,
    output logic        vblank_start,
    output logic        vblank_end_soon,
    output logic        pix_stb,
    output logic        hdmi_de,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic [23:0] hdmi_rgb
);

    logic        raw_de;
    logic        raw_hsync;
    logic        raw_vsync;
    logic        de_d1;
    logic        hs_d1;
    logic        vs_d1;
    logic        sel_hi;
    logic [23:0] colour;
    logic        unused_pal_bits;

    video_timing_gen #(
        .CLKS_PER_PIXEL(CLKS_PER_PIXEL),
        .H_VISIBLE     (H_VISIBLE),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_VISIBLE     (V_VISIBLE),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK),
        .VEND_LEAD     (VEND_LEAD)
    ) u_timing (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_stb        (pix_stb),
        .src_x          (hdmi_rowram_rdaddr),
        .raw_de         (raw_de),
        .raw_hsync      (raw_hsync),
        .raw_vsync      (raw_vsync),
        .rowram_swap    (rowram_swap),
        .next_row       (next_row),
        .vblank_start   (vblank_start),
        .vblank_end_soon(vblank_end_soon)
    );

    // Alpha/pad bytes of each palette colour are not used.
    assign unused_pal_bits = ^{hdmi_palram_rddata[63:56], hdmi_palram_rddata[31:24]};

    assign colour = sel_hi ? hdmi_palram_rddata[55:32] : hdmi_palram_rddata[23:0];

    // Stage 1 latches the row-buffer index (address went out one pixel ago);
    // stage 2 latches the palette colour. Syncs/DE travel alongside so they
    // stay aligned with the colour they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdmi_palram_rdaddr <= '0;
            sel_hi             <= 1'b0;
            de_d1              <= 1'b0;
            hs_d1              <= 1'b1;
            vs_d1              <= 1'b1;
            hdmi_de            <= 1'b0;
            hdmi_hsync         <= 1'b1;
            hdmi_vsync         <= 1'b1;
            hdmi_rgb           <= '0;
        end else if (pix_stb) begin
            hdmi_palram_rdaddr <= hdmi_rowram_rddata[9:1];
            sel_hi             <= hdmi_rowram_rddata[0];
            de_d1              <= raw_de;
            hs_d1              <= raw_hsync;
            vs_d1              <= raw_vsync;
            hdmi_de            <= de_d1;
            hdmi_hsync         <= hs_d1;
            hdmi_vsync         <= vs_d1;
            hdmi_rgb           <= de_d1 ? colour : '0;
        end
    end

endmodule

// File: tb/tb_hdmi_video_output.sv
// Directed bench for hdmi_video_output. Horizontal timing is shrunk to 24
// pixels per line to keep whole frames short; vertical timing is the real
// 525-line frame so the full swap sequence is exercised.
module tb_hdmi_video_output;

    localparam int unsigned CPP  = 2;
    localparam int unsigned HV   = 16;
    localparam int unsigned HF   = 2;
    localparam int unsigned HSW  = 4;
    localparam int unsigned HB   = 2;
    localparam int unsigned HT   = HV + HF + HSW + HB;   // 24
    localparam int unsigned VV   = 480;
    localparam int unsigned VF   = 10;
    localparam int unsigned VSW  = 2;
    localparam int unsigned VB   = 33;
    localparam int unsigned VT   = VV + VF + VSW + VB;   // 525
    localparam int unsigned LEAD = 3;

    // vblank_end_soon is the strobe closing line 521: the 42*HT-th strobe
    // after release (lines 480..521). Strobe k is seen k*CPP-1 clocks in.
    localparam int unsigned VEND_CLKS  = 42 * HT * CPP - 1;   // 2015
    localparam int unsigned VEND_TO_VS = 483 * HT * CPP;      // 23184
    localparam int unsigned FRAME_CLKS = VT * HT * CPP;       // 25200
    localparam int unsigned HS_LOW     = VT * HSW * CPP;      // 4200
    localparam int unsigned VS_LOW     = VSW * HT * CPP;      // 96

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } pix_t;

    localparam pix_t RST_PIX = {1'b0, 1'b1, 1'b1, 24'h000000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  hdmi_rowram_rdaddr;
    logic [9:0]  hdmi_rowram_rddata = '0;
    logic [8:0]  hdmi_palram_rdaddr;
    logic [63:0] hdmi_palram_rddata = '0;
    logic        rowram_swap;
    logic [7:0]  next_row;
    logic        vblank_start;
    logic        vblank_end_soon;
    logic        pix_stb;
    logic        hdmi_de;
    logic        hdmi_hsync;
    logic        hdmi_vsync;
    logic [23:0] hdmi_rgb;

    always #5 clk = ~clk;

    hdmi_video_output #(
        .CLKS_PER_PIXEL(CPP),
        .H_VISIBLE     (HV),
        .H_FRONT       (HF),
        .H_SYNC        (HSW),
        .H_BACK        (HB),
        .V_VISIBLE     (VV),
        .V_FRONT       (VF),
        .V_SYNC        (VSW),
        .V_BACK        (VB),
        .VEND_LEAD     (LEAD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hdmi_rowram_rdaddr(hdmi_rowram_rdaddr),
        .hdmi_rowram_rddata(hdmi_rowram_rddata),
        .hdmi_palram_rdaddr(hdmi_palram_rdaddr),
        .hdmi_palram_rddata(hdmi_palram_rddata),
        .rowram_swap       (rowram_swap),
        .next_row          (next_row),
        .vblank_start      (vblank_start),
        .vblank_end_soon   (vblank_end_soon),
        .pix_stb           (pix_stb),
        .hdmi_de           (hdmi_de),
        .hdmi_hsync        (hdmi_hsync),
        .hdmi_vsync        (hdmi_vsync),
        .hdmi_rgb          (hdmi_rgb)
    );

    // Row RAM: index 3 at address 5, nonzero everywhere else.
    function automatic logic [9:0] row_word(input logic [8:0] a);
        logic [9:0] t;
        t = 10'(a) * 10'd37 + 10'd101;
        return (a == 9'd5) ? 10'h003 : t;
    endfunction

    // Palette: word 1 fixed; others nonzero with junk in the ignored bytes.
    function automatic logic [63:0] pal_word(input logic [8:0] a);
        logic [23:0] hi;
        logic [23:0] lo;
        hi = 24'(a) * 24'h010203 + 24'h0A0000;
        lo = 24'(a) * 24'h030201 + 24'h000B00;
        return (a == 9'd1) ? 64'h00AABBCC_00112233 : {8'hFF, hi, 8'hEE, lo};
    endfunction

    always @(posedge clk) begin
        hdmi_rowram_rddata <= row_word(hdmi_rowram_rdaddr);
        hdmi_palram_rddata <= pal_word(hdmi_palram_rdaddr);
    end

    function automatic pix_t exp_pixel(input int unsigned x, input int unsigned y);
        pix_t        p;
        logic [9:0]  idx;
        logic [63:0] w;
        p.de  = (x < HV) && (y < VV);
        p.hs  = !((x >= HV + HF) && (x < HV + HF + HSW));
        p.vs  = !((y >= VV + VF) && (y < VV + VF + VSW));
        idx   = row_word(9'(x / 2));
        w     = pal_word(idx[9:1]);
        p.rgb = !p.de ? 24'h000000 : (idx[0] ? w[55:32] : w[23:0]);
        return p;
    endfunction

    // {hit, row} for a line end.
    function automatic logic [8:0] swap_of(input int unsigned line);
        if (line == VT - 3)                  return {1'b1, 8'd0};
        if (line == VT - 1)                  return {1'b1, 8'd1};
        if (line == VV - 3)                  return {1'b1, 8'd0};
        if ((line % 2 == 1) && (line < VV - 3)) return {1'b1, 8'((line - 1) / 2 + 2)};
        return 9'd0;
    endfunction

    int n_assert = 0;
    int n_fail   = 0;

    int unsigned bh, bv, ph, cyc;
    pix_t        d1, d2;
    int unsigned d1x, d1y, d2x, d2y;
    logic [7:0]  exp_nr;
    int unsigned n_vend, vend_cyc, n_vs, vs_cyc1, vs_cyc2;
    int unsigned hs_low, vs_low, blank_swaps;
    bit          capture, cap_done, in_blank;
    logic [7:0]  seq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bh = 0; bv = VV; ph = 0; cyc = 0;
        d1 = RST_PIX; d2 = RST_PIX;
        d1x = 9999; d1y = 9999; d2x = 9999; d2y = 9999;
        exp_nr = 8'd0;
    endtask

    task automatic check_reset_values(input string when);
        chk({when, "_hsync"}, 64'(hdmi_hsync), 64'(1'b1));
        chk({when, "_vsync"}, 64'(hdmi_vsync), 64'(1'b1));
        chk({when, "_de"}, 64'(hdmi_de), 64'(1'b0));
        chk({when, "_rgb"}, 64'(hdmi_rgb), 64'(24'h0));
        chk({when, "_pix_stb"}, 64'(pix_stb), 64'(1'b0));
        chk({when, "_swap"}, 64'(rowram_swap), 64'(1'b0));
        chk({when, "_next_row"}, 64'(next_row), 64'(8'd0));
        chk({when, "_vblank_start"}, 64'(vblank_start), 64'(1'b0));
        chk({when, "_vend_soon"}, 64'(vblank_end_soon), 64'(1'b0));
        chk({when, "_rowram_addr"}, 64'(hdmi_rowram_rdaddr), 64'(9'd0));
        chk({when, "_palram_addr"}, 64'(hdmi_palram_rdaddr), 64'(9'd0));
    endtask

    // One clock: sample at the falling edge against the position model.
    task automatic step();
        bit         stb, le;
        logic [8:0] sw;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ph  = (ph + 1) % CPP;
        stb = (ph == CPP - 1);
        le  = stb && (bh == HT - 1);
        sw  = swap_of(bv);
        chk("pix_stb", 64'(pix_stb), 64'(stb));
        chk("vblank_start", 64'(vblank_start), 64'(le && (bv == VV - 1)));
        chk("vblank_end_soon", 64'(vblank_end_soon), 64'(le && (bv == VT - 1 - LEAD)));
        chk("rowram_swap", 64'(rowram_swap), 64'(le && sw[8]));
        chk("next_row", 64'(next_row), 64'((le && sw[8]) ? sw[7:0] : exp_nr));
        chk("hdmi_de", 64'(hdmi_de), 64'(d2.de));
        chk("hdmi_hsync", 64'(hdmi_hsync), 64'(d2.hs));
        chk("hdmi_vsync", 64'(hdmi_vsync), 64'(d2.vs));
        chk("hdmi_rgb", 64'(hdmi_rgb), 64'(d2.rgb));
        if (d2y == 0 && (d2x == 10 || d2x == 11)) begin
            chk("line0_px10_11_rgb", 64'(hdmi_rgb), 64'(24'hAABBCC));
            chk("line0_px10_11_de", 64'(hdmi_de), 64'(1'b1));
        end

        if (hdmi_hsync === 1'b0) hs_low++;
        if (hdmi_vsync === 1'b0) vs_low++;
        if (rowram_swap === 1'b1) begin
            if (capture) seq.push_back(next_row);
            if (in_blank) blank_swaps++;
        end
        if (vblank_end_soon === 1'b1) begin
            n_vend++;
            vend_cyc = cyc;
            in_blank = 1'b0;
            if (!cap_done) capture = 1'b1;
        end
        if (vblank_start === 1'b1) begin
            n_vs++;
            if (n_vs == 1) vs_cyc1 = cyc;
            if (n_vs == 2) vs_cyc2 = cyc;
            in_blank = 1'b1;
            if (capture) cap_done = 1'b1;
            capture = 1'b0;
        end

        if (stb) begin
            d2 = d1; d2x = d1x; d2y = d1y;
            d1 = exp_pixel(bh, bv); d1x = bh; d1y = bv;
            if (bh == HT - 1) begin
                bh = 0;
                bv = (bv == VT - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
        if (le && sw[8]) exp_nr = sw[7:0];
    endtask

    initial begin
        n_vend = 0; vend_cyc = 0; n_vs = 0; vs_cyc1 = 0; vs_cyc2 = 0;
        hs_low = 0; vs_low = 0; blank_swaps = 0;
        capture = 1'b0; cap_done = 1'b0; in_blank = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        #1;
        check_reset_values("at_release");

        // First vblank_end_soon after release.
        for (int g = 0; g < 4000 && n_vend < 1; g++) step();
        chk("first_vend_clks", 64'(vend_cyc), 64'(VEND_CLKS));

        // First vblank_start; the swap sequence of one frame is captured between.
        for (int g = 0; g < 30000 && n_vs < 1; g++) step();
        chk("vend_to_vblank_clks", 64'(vs_cyc1 - vend_cyc), 64'(VEND_TO_VS));
        chk("swap_count", 64'(seq.size()), 64'(241));
        for (int i = 0; i < seq.size() && i < 241; i++) begin
            chk("swap_next_row_seq", 64'(seq[i]), 64'((i == 240) ? 0 : i));
        end

        // One full frame: period and sync widths.
        hs_low = 0; vs_low = 0; blank_swaps = 0;
        for (int g = 0; g < 30000 && n_vs < 2; g++) step();
        chk("frame_period_clks", 64'(vs_cyc2 - vs_cyc1), 64'(FRAME_CLKS));
        chk("hsync_low_clks", 64'(hs_low), 64'(HS_LOW));
        chk("vsync_low_clks", 64'(vs_low), 64'(VS_LOW));
        chk("swaps_in_vblank", 64'(blank_swaps), 64'(0));

        // Mid-frame reset, landing on the swap pulse closing line 199.
        for (int g = 0; g < 20000 && !(ph == 0 && bh == HT - 1 && bv == 199); g++) step();
        @(posedge clk);
        #1;
        chk("pre_reset_swap", 64'(rowram_swap), 64'(1'b1));
        chk("pre_reset_next_row", 64'(next_row), 64'(8'd101));
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        n_vend = 0; vend_cyc = 0;
        repeat (2) @(negedge clk);
        check_reset_values("mid_reset_hold");
        rst_n = 1'b1;
        for (int g = 0; g < 4000 && n_vend < 1; g++) step();
        chk("vend_after_mid_reset_clks", 64'(vend_cyc), 64'(VEND_CLKS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
